// File: rtl/dcpu16_memarb.sv
// dcpu16_memarb: round-robin merge of the fetch and data buses onto one single-port memory bus,
// with registered memory-side outputs and a watchdog that errors out unacknowledged cycles.
module dcpu16_memarb #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int TOW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fs_stb,
  input  logic          fs_wre,
  input  logic [AW-1:0] fs_adr,
  input  logic [DW-1:0] fs_dto,
  output logic [DW-1:0] fs_dti,
  output logic          fs_ack,
  output logic          fs_err,
  input  logic          ab_stb,
  input  logic          ab_wre,
  input  logic [AW-1:0] ab_adr,
  input  logic [DW-1:0] ab_dto,
  output logic [DW-1:0] ab_dti,
  output logic          ab_ack,
  output logic          ab_err,
  output logic          mm_stb,
  output logic          mm_wre,
  output logic [AW-1:0] mm_adr,
  output logic [DW-1:0] mm_dto,
  input  logic [DW-1:0] mm_dti,
  input  logic          mm_ack
);
  typedef enum logic [1:0] {IDLE, GNT_FS, GNT_AB, DONE} state_t;
  state_t state, state_nx;
  logic last;
  logic [TOW-1:0] wdog;
  logic to, fs_sel, g_fs, g_ab, req;
  // last=1 means the data bus was served most recently, so fetch wins a tie
  assign fs_sel = fs_stb & (~ab_stb | last);
  assign req = fs_stb | ab_stb;
  assign to = &wdog;
  assign g_fs = state == GNT_FS;
  assign g_ab = state == GNT_AB;
  always_comb begin
    state_nx = state == IDLE ? (fs_sel ? GNT_FS : ab_stb ? GNT_AB : IDLE) :
               state == DONE ? IDLE :
               (mm_ack | to) ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last   <= 1'b0;
      wdog   <= '0;
      mm_stb <= 1'b0;
      mm_wre <= 1'b0;
      mm_adr <= '0;
      mm_dto <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        mm_stb <= 1'b1;
        mm_wre <= fs_sel ? fs_wre : ab_wre;
        mm_adr <= fs_sel ? fs_adr : ab_adr;
        mm_dto <= fs_sel ? fs_dto : ab_dto;
        wdog   <= '0;
        last   <= ~fs_sel;
      end else if (g_fs | g_ab) begin
        wdog <= wdog + 1'b1;
        if (mm_ack | to) mm_stb <= 1'b0;
      end
    end
  end
  // a real acknowledge always beats a timeout in the same cycle
  assign fs_ack = g_fs & (mm_ack ? fs_stb : to);
  assign ab_ack = g_ab & (mm_ack ? ab_stb : to);
  assign fs_err = g_fs & ~mm_ack & to;
  assign ab_err = g_ab & ~mm_ack & to;
  assign fs_dti = g_fs ? (mm_ack ? mm_dti : {DW{to}}) : '0;
  assign ab_dti = g_ab ? (mm_ack ? mm_dti : {DW{to}}) : '0;
endmodule

// File: doc/dcpu16_memarb.md
# dcpu16_memarb

Two-port to single-port memory arbiter for the DCPU16 core. It merges the CPU's instruction-fetch bus (fs_*) and data bus (ab_*) onto one single-port memory bus (mm_*), so the core can run from a single-port SRAM instead of a dual-port one. It uses round-robin grant and registered memory-side outputs. A bus watchdog terminates any memory cycle that is never acknowledged and flags an error to the requester.

## Interface
- AW, 16, address width
- DW, 16, data width
- TOW, 4, watchdog counter width; a memory cycle times out after 2^TOW-1 cycles without mm_ack
---
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- fs_stb  in  1  fetch request strobe, held until fs_ack
- fs_wre  in  1  fetch write enable
- fs_adr  in  AW  fetch address
- fs_dto  in  DW  fetch write data
- fs_dti  out  DW  fetch read data, valid with fs_ack
- fs_ack  out  1  fetch acknowledge, one-cycle pulse
- fs_err  out  1  fetch bus error, one-cycle pulse coincident with fs_ack
- ab_stb, ab_wre, ab_adr, ab_dto, ab_dti, ab_ack, ab_err: same as the fs_* ports, for the data bus
- mm_stb  out  1  memory strobe, registered
- mm_wre  out  1  memory write enable, registered
- mm_adr  out  AW  memory address, registered
- mm_dto  out  DW  memory write data, registered
- mm_dti  in  DW  memory read data
- mm_ack  in  1  memory acknowledge

## Operation
- States:
  - IDLE: no memory cycle; mm_stb=0.
  - GNT_FS / GNT_AB: cycle in progress for that port.
  - DONE: one-cycle turnaround. Because requesters drop stb only after seeing ack, this state prevents re-granting a stale strobe.
- IDLE transitions:
  - Only fs_stb set -> GNT_FS.
  - Only ab_stb set -> GNT_AB.
  - Both set -> grant the port that was not served last (the `last` flag). After reset `last`=FS, so ab wins the first tie.
- On a grant edge:
  - Latch the granted port's adr/wre/dto into mm_adr/mm_wre/mm_dto.
  - Set mm_stb=1, clear the watchdog counter, update `last`.
- GNT_x while mm_ack=0:
  - Watchdog increments.
  - At all-ones: timeout. x_ack=1 and x_err=1 for that cycle, x_dti forced to all ones, state -> DONE.
- GNT_x with mm_ack=1:
  - x_ack = x_stb (combinational). x_dti = mm_dti (combinational pass-through). x_err=0.
  - Next edge: state -> DONE, mm_stb -> 0.
- Abandoned request: if x_stb drops while GNT_x, the memory cycle still completes. The ack is suppressed (x_ack = mm_ack & GNT_x & x_stb).
- Ungranted port: ack=0, err=0, dti=0.
- DONE: state -> IDLE on the next edge unconditionally.
- Reset asserted: asynchronously forces the following, including mid-cycle. Any in-flight memory cycle is dropped.
  - State = IDLE, `last` = FS.
  - mm_stb=0, mm_wre=0, mm_adr=0, mm_dto=0.
  - Watchdog = 0.
  - All acks and errs = 0.
- mm_adr, mm_dto and mm_wre hold their values outside grants (no toggling).

## Timing
- Request sampled at edge E0 with state IDLE.
- mm_stb high from E0 until the edge that samples mm_ack.
- Memory with one-cycle ack (ack registered from stb): x_ack is seen in the cycle after E0+1, i.e. 2 cycles of request-to-ack latency.
- Throughput: one access per 4 cycles per arbiter (grant, mem, ack, DONE), with 1-cycle memory.
- Alternating requesters under full contention: each port served every other access. No starvation.
- Timeout: x_ack/x_err asserted exactly 2^TOW-1 cycles after the grant edge when mm_ack stays low. A late mm_ack arriving in DONE/IDLE is ignored.
- mm_ack and timeout in the same cycle: mm_ack wins. Normal ack, err=0, real data returned.

## Test plan
- Reset: drive rst=0 mid-transaction with mm_stb=1 -> mm_stb=0 and all acks/errs 0 immediately (before the next clk edge). Release rst -> first tie grants ab.
- Single read: fs_stb=1, fs_adr=16'h0010, memory returns 16'hBEEF after one cycle -> mm_adr=16'h0010 one edge later, fs_ack pulse with fs_dti=16'hBEEF two cycles after request, mm_stb low one edge later.
- Write: ab_stb=1, ab_wre=1, ab_adr=16'h8000, ab_dto=16'h1234 -> mm_wre=1, mm_adr=16'h8000, mm_dto=16'h1234, ab_ack single pulse, fs_ack stays 0.
- Contention: fs_stb and ab_stb held high, each dropped for one cycle after its own ack and then re-raised, for 8 accesses -> grant order ab, fs, ab, fs…; 4 acks on each port.
- Timeout with TOW=4, mm_ack tied low, fs read -> fs_ack=fs_err=1 with fs_dti=16'hFFFF exactly 15 cycles after the grant edge. A subsequent ab request is then served normally.
- Abandon: ab_stb dropped one cycle after grant, memory acks late -> ab_ack never asserts, arbiter returns to IDLE via DONE, and a new fs request is granted afterwards.
